// File: rtl/branch_predict_ctrl.sv
// Branch/jump resolution for execute plus a PC-indexed table of 2-bit saturating
// counters that predicts fetch, with a registered flush and saturating statistics.
module branch_predict_ctrl #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_branch,
    input  logic             ex_zero,
    input  logic             ex_result0,
    input  logic             ex_pred_taken,
    output logic             nxt_a_src,
    output logic             nxt_b_src,
    output logic             mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_table [DEPTH];
    logic             r_flush;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_a_src;
    logic             w_b_src;
    logic             w_cond;
    logic             w_mis;
    logic             w_unused_bits;

    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_cond        = ex_valid & ex_branch[2];
    assign w_unused_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                             ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    always_comb begin
        w_a_src = 1'b0;
        w_b_src = 1'b0;
        if (ex_valid) begin
            case (ex_branch)
                3'b001:  w_b_src = 1'b1;
                3'b010: begin
                    w_a_src = 1'b1;
                    w_b_src = 1'b1;
                end
                3'b100:  w_b_src = ex_zero;
                3'b101:  w_b_src = ~ex_zero;
                3'b110:  w_b_src = ex_result0;
                3'b111:  w_b_src = ex_zero | ~ex_result0;
                default: w_b_src = 1'b0;
            endcase
        end
    end

    // jalr targets come from a register and are never predicted, so they always flush.
    always_comb begin
        w_mis = 1'b0;
        if (ex_valid) begin
            if (ex_branch[2]) begin
                w_mis = w_b_src ^ ex_pred_taken;
            end else begin
                case (ex_branch)
                    3'b001:  w_mis = ~ex_pred_taken;
                    3'b010:  w_mis = 1'b1;
                    default: w_mis = ex_pred_taken;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_table[gi] <= 2'b01;
                end else if (w_cond && (w_ex_idx == IDX_W'(gi))) begin
                    if (w_b_src && (r_table[gi] != 2'b11)) begin
                        r_table[gi] <= r_table[gi] + 2'b01;
                    end else if (!w_b_src && (r_table[gi] != 2'b00)) begin
                        r_table[gi] <= r_table[gi] - 2'b01;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush <= w_mis;
            if (w_cond && (r_branch_cnt != CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mis && (r_mispred_cnt != CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign pred_taken  = r_table[w_fetch_idx][1];
    assign nxt_a_src   = w_a_src;
    assign nxt_b_src   = w_b_src;
    assign mispredict  = w_mis;
    assign flush       = r_flush;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: resolution vector table, directed corner sequences and
// randomized traffic against a behavioural predictor model; a CNT_W=2 copy checks saturation.
module tb_branch_predict_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [2:0]  ex_branch = '0;
    logic        ex_zero = 1'b0;
    logic        ex_result0 = 1'b0;
    logic        ex_pred_taken = 1'b0;

    logic        pred_taken, nxt_a_src, nxt_b_src, mispredict, flush;
    logic [15:0] branch_cnt, mispred_cnt;
    logic        pred_taken2, nxt_a2, nxt_b2, mispredict2, flush2;
    logic [1:0]  branch_cnt2, mispred_cnt2;

    always #5 clk = ~clk;

    branch_predict_ctrl u_dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_result0(ex_result0), .ex_pred_taken(ex_pred_taken),
        .nxt_a_src(nxt_a_src), .nxt_b_src(nxt_b_src), .mispredict(mispredict),
        .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predict_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken2),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_result0(ex_result0), .ex_pred_taken(ex_pred_taken),
        .nxt_a_src(nxt_a2), .nxt_b_src(nxt_b2), .mispredict(mispredict2),
        .flush(flush2), .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: counter value 0..3 per entry, prediction = value >= 2.
    int m_tbl [64];
    int m_br, m_mp;
    bit m_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_br = 0;
        m_mp = 0;
        m_flush = 0;
    endtask

    // Outcome from the Branch code rules: taken, register-based target, mispredicted.
    task automatic resolve(output bit a, output bit b, output bit mis);
        bit cond;
        a = 0; b = 0; mis = 0;
        cond = ex_branch[2];
        if (ex_valid) begin
            if (ex_branch == 3'd1) b = 1;
            else if (ex_branch == 3'd2) begin a = 1; b = 1; end
            else if (ex_branch == 3'd4) b = ex_zero;
            else if (ex_branch == 3'd5) b = !ex_zero;
            else if (ex_branch == 3'd6) b = ex_result0;
            else if (ex_branch == 3'd7) b = ex_zero || !ex_result0;
            if (cond) mis = (b != ex_pred_taken);
            else if (ex_branch == 3'd1) mis = !ex_pred_taken;
            else if (ex_branch == 3'd2) mis = 1;
            else mis = ex_pred_taken;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_flush", flush, 0);
        chk("rst_brcnt", branch_cnt, 0);
        chk("rst_mpcnt", mispred_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: check combinational outputs, take the edge, update model, check state.
    task automatic cycle(input string tag);
        bit a, b, mis;
        int idx;
        #1;
        resolve(a, b, mis);
        chk({tag, "_a"}, nxt_a_src, a);
        chk({tag, "_b"}, nxt_b_src, b);
        chk({tag, "_mis"}, mispredict, mis);
        chk({tag, "_pred"}, pred_taken, (m_tbl[fetch_pc[7:2]] >= 2));
        @(posedge clk);
        if (ex_valid && ex_branch[2]) begin
            idx = ex_pc[7:2];
            m_tbl[idx] = b ? sat(m_tbl[idx] + 1, 3) : ((m_tbl[idx] > 0) ? m_tbl[idx] - 1 : 0);
            m_br++;
        end
        if (mis) m_mp++;
        m_flush = mis;
        #1;
        chk({tag, "_flush"}, flush, m_flush);
        chk({tag, "_brcnt"}, branch_cnt, sat(m_br, 65535));
        chk({tag, "_mpcnt"}, mispred_cnt, sat(m_mp, 65535));
        chk({tag, "_brcnt2"}, branch_cnt2, sat(m_br, 3));
        chk({tag, "_mpcnt2"}, mispred_cnt2, sat(m_mp, 3));
        $display("%s: pc=0x%0h br=%0d z=%0d r0=%0d pt=%0d -> a=%0d b=%0d mis=%0d flush=%0d",
                 tag, ex_pc, ex_branch, ex_zero, ex_result0, ex_pred_taken,
                 nxt_a_src, nxt_b_src, mispredict, flush);
    endtask

    task automatic set_ex(input bit v, input logic [31:0] pc, input logic [2:0] br,
                          input bit z, input bit r0, input bit pt);
        ex_valid = v; ex_pc = pc; ex_branch = br;
        ex_zero = z; ex_result0 = r0; ex_pred_taken = pt;
    endtask

    typedef struct {
        bit       v;
        bit [2:0] br;
        bit       z;
        bit       r0;
        bit       pt;
        bit       exp_a;
        bit       exp_b;
        bit       exp_mis;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{1, 3'd0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 3'd0, 0, 0, 1, 0, 0, 1};
        vecs[2]  = '{1, 3'd1, 0, 0, 0, 0, 1, 1};
        vecs[3]  = '{1, 3'd1, 0, 0, 1, 0, 1, 0};
        vecs[4]  = '{1, 3'd2, 0, 0, 1, 1, 1, 1};
        vecs[5]  = '{1, 3'd2, 1, 1, 0, 1, 1, 1};
        vecs[6]  = '{1, 3'd3, 1, 1, 0, 0, 0, 0};
        vecs[7]  = '{1, 3'd4, 1, 0, 1, 0, 1, 0};
        vecs[8]  = '{1, 3'd4, 0, 0, 1, 0, 0, 1};
        vecs[9]  = '{1, 3'd5, 0, 0, 0, 0, 1, 1};
        vecs[10] = '{1, 3'd5, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 3'd6, 0, 1, 1, 0, 1, 0};
        vecs[12] = '{1, 3'd6, 0, 0, 1, 0, 0, 1};
        vecs[13] = '{1, 3'd7, 0, 0, 0, 0, 1, 1};
        vecs[14] = '{1, 3'd7, 0, 1, 0, 0, 0, 0};
        vecs[15] = '{1, 3'd7, 1, 1, 1, 0, 1, 0};
        vecs[16] = '{0, 3'd2, 1, 0, 1, 0, 0, 0};

        // Reset state and an all-entries prediction sweep
        do_reset();
        for (int i = 0; i < 64; i++) begin
            fetch_pc = 32'(i * 4);
            #1 chk("t1_pred", pred_taken, 0);
        end

        // beq always taken on one entry: 01 -> 10 -> 11 -> 11
        fetch_pc = 32'h40;
        set_ex(1, 32'h40, 3'd4, 1, 0, 1);
        cycle("t2_e1");
        chk("t2_pred_after1", pred_taken, 1);
        cycle("t2_e2");
        cycle("t2_e3");
        chk("t2_brcnt", branch_cnt, 3);
        chk("t2_pred_final", pred_taken, 1);

        // Resolution vector table
        do_reset();
        for (int i = 0; i < 17; i++) begin
            fetch_pc = 32'(32'h100 + i * 4);
            set_ex(vecs[i].v, 32'(32'h100 + i * 4), vecs[i].br, vecs[i].z, vecs[i].r0, vecs[i].pt);
            #1;
            chk($sformatf("vec%0d_a", i), nxt_a_src, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), nxt_b_src, vecs[i].exp_b);
            chk($sformatf("vec%0d_mis", i), mispredict, vecs[i].exp_mis);
            cycle($sformatf("vec%0d", i));
        end

        // Flush is a single-cycle pulse after a bge mispredict
        do_reset();
        set_ex(1, 32'h10, 3'd7, 0, 0, 0);
        cycle("t3_bge");
        chk("t3_flush1", flush, 1);
        set_ex(1, 32'h10, 3'd6, 0, 1, 1);
        cycle("t3_blt");
        chk("t3_flush_blt", flush, 0);
        set_ex(0, 32'h0, 3'd0, 0, 0, 0);
        cycle("t3_idle");
        chk("t3_flush2", flush, 0);

        // jalr always mispredicts and leaves the table alone; jal predicted taken is fine
        do_reset();
        fetch_pc = 32'h20;
        set_ex(1, 32'h20, 3'd2, 1, 1, 1);
        cycle("t4_jalr");
        chk("t4_pred_unch", pred_taken, 0);
        chk("t4_brcnt", branch_cnt, 0);
        set_ex(1, 32'h20, 3'd1, 0, 0, 1);
        cycle("t4_jal");
        chk("t4_flush_jal", flush, 0);

        // Same-index read during write returns the old counter
        do_reset();
        fetch_pc = 32'h80;
        set_ex(1, 32'h80, 3'd5, 0, 0, 0);
        #1 chk("t5_pred_before", pred_taken, 0);
        cycle("t5_bne");
        set_ex(0, 32'h0, 3'd0, 0, 0, 0);
        chk("t5_pred_after", pred_taken, 1);

        // Saturation of the narrow counter and asynchronous mid-stream reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_ex(1, 32'(32'h200 + i * 4), 3'd4, 1, 0, 0);
            cycle($sformatf("t6_beq%0d", i));
        end
        chk("t6_mpcnt2_sat", mispred_cnt2, 3);
        chk("t6_mpcnt_wide", mispred_cnt, 5);
        chk("t6_flush_pre", flush, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_flush", flush, 0);
        chk("t6_rst_mpcnt", mispred_cnt, 0);
        chk("t6_rst_mpcnt2", mispred_cnt2, 0);
        chk("t6_rst_brcnt", branch_cnt, 0);
        set_ex(0, 32'h0, 3'd0, 0, 0, 0);
        do_reset();
        fetch_pc = 32'h200;
        #1 chk("t6_rst_table", pred_taken, 0);

        // Randomized traffic over a small PC window so entries collide
        for (int i = 0; i < 400; i++) begin
            fetch_pc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            set_ex(($urandom_range(0, 7) != 0),
                   {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00},
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
